// File: rtl/red_centroid_tracker.sv
// Red-pixel classifier, per-frame accumulator and sequential centroid divider.
// Optional macro CENTROID_Y_EN enables the Y sum and the second divide pass.
module red_centroid_tracker #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int DEADBAND   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pixel,
  input  logic        pixel_valid,
  input  logic        sop,
  input  logic        eop,
  input  logic [3:0]  red_min,
  input  logic [3:0]  other_max,
  input  logic [16:0] min_pixels,
  output logic [16:0] red_count,
  output logic [8:0]  centroid_x,
  output logic [7:0]  centroid_y,
  output logic [1:0]  steer,
  output logic        result_valid,
  output logic        overrun,
  output logic        busy
);
  localparam int CW = 17;
  localparam int SW = 25;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int LEFT_LIM  = IMG_WIDTH / 2 - DEADBAND;
  localparam int RIGHT_LIM = IMG_WIDTH / 2 + DEADBAND;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {D_IDLE, D_X, D_Y, D_OUT} dstate_t;

  function automatic logic is_red(input logic [11:0] p, input logic [3:0] rmin,
                                  input logic [3:0] omax);
    return (p[11:8] >= rmin) && (p[7:4] < omax) && (p[3:0] < omax);
  endfunction

  function automatic logic [YW-1:0] y_step(input logic [YW-1:0] yv);
    return (yv == Y_LAST) ? yv : yv + 1'b1;
  endfunction

  function automatic logic [1:0] steer_of(input logic [CW-1:0] cnt, input logic [CW-1:0] minp,
                                          input logic [XW-1:0] cx);
    int cxi;
    cxi = int'(cx);
    if (cnt < minp)      return 2'b00;
    if (cxi < LEFT_LIM)  return 2'b01;
    if (cxi > RIGHT_LIM) return 2'b11;
    return 2'b10;
  endfunction

  dstate_t       state;
  logic [4:0]    iter;
  logic          frame_active, accept, red_hit, start;
  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;
  logic [CW-1:0] cnt, cnt_nxt, sh_cnt;
  logic [SW-1:0] sum_x, sx_nxt;
  logic [SW-1:0] rem, q, rem_nxt, q_nxt;
  logic [SW:0]   trial;
  logic          take;
  logic [XW-1:0] cx_res;
`ifdef CENTROID_Y_EN
  logic [SW-1:0] sum_y, sy_nxt, sh_sy;
  logic [XW-1:0] qx;
  logic [YW-1:0] cy_res, cy_q;
`endif

  // Accumulation stage: position of the current beat and running totals
  always_comb begin
    accept  = pixel_valid && (frame_active || sop);
    red_hit = is_red(pixel, red_min, other_max);
    px      = sop ? '0 : x;
    py      = sop ? '0 : y;
    cnt_nxt = (sop ? '0 : cnt) + CW'(red_hit);
    sx_nxt  = (sop ? '0 : sum_x) + (red_hit ? SW'(px) : '0);
`ifdef CENTROID_Y_EN
    sy_nxt  = (sop ? '0 : sum_y) + (red_hit ? SW'(py) : '0);
`endif
    start   = accept && eop && (state == D_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_active <= 1'b0;
      x <= '0;
      y <= '0;
      cnt <= '0;
      sum_x <= '0;
      sh_cnt <= '0;
      overrun <= 1'b0;
`ifdef CENTROID_Y_EN
      sum_y <= '0;
      sh_sy <= '0;
`endif
    end else if (accept) begin
      x <= (px == X_LAST) ? '0 : px + 1'b1;
      y <= (px == X_LAST) ? y_step(py) : py;
      if (eop) begin
        frame_active <= 1'b0;
        cnt <= '0;
        sum_x <= '0;
`ifdef CENTROID_Y_EN
        sum_y <= '0;
`endif
        // A frame finishing while the divider is busy is dropped wholesale
        if (state == D_IDLE) begin
          sh_cnt <= cnt_nxt;
`ifdef CENTROID_Y_EN
          sh_sy <= sy_nxt;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        frame_active <= 1'b1;
        cnt <= cnt_nxt;
        sum_x <= sx_nxt;
`ifdef CENTROID_Y_EN
        sum_y <= sy_nxt;
`endif
      end
    end
  end

  // Divide stage: one restoring step per cycle, dividend shifted out of q
  always_comb begin
    trial   = {rem, q[SW-1]};
    take    = trial >= (SW+1)'(sh_cnt);
    rem_nxt = take ? SW'(trial - (SW+1)'(sh_cnt)) : SW'(trial);
    q_nxt   = {q[SW-2:0], take};
`ifdef CENTROID_Y_EN
    cx_res  = (sh_cnt == '0) ? '0 : qx;
    cy_res  = (sh_cnt == '0) ? '0 : q_nxt[YW-1:0];
`else
    cx_res  = (sh_cnt == '0) ? '0 : q_nxt[XW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= D_IDLE;
      iter <= '0;
      rem <= '0;
      q <= '0;
      busy <= 1'b0;
      result_valid <= 1'b0;
      red_count <= '0;
      centroid_x <= '0;
      steer <= 2'b00;
`ifdef CENTROID_Y_EN
      qx <= '0;
      cy_q <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        D_IDLE: begin
          if (start) begin
            state <= D_X;
            busy <= 1'b1;
            iter <= '0;
            rem <= '0;
            q <= sx_nxt;
          end
        end
        D_X: begin
          rem <= rem_nxt;
          q <= q_nxt;
          iter <= iter + 5'd1;
          if (iter == 5'd24) begin
            iter <= '0;
            rem <= '0;
`ifdef CENTROID_Y_EN
            qx <= q_nxt[XW-1:0];
            q <= sh_sy;
            state <= D_Y;
`else
            state <= D_OUT;
            result_valid <= 1'b1;
            red_count <= sh_cnt;
            centroid_x <= cx_res;
            steer <= steer_of(sh_cnt, min_pixels, cx_res);
`endif
          end
        end
`ifdef CENTROID_Y_EN
        D_Y: begin
          rem <= rem_nxt;
          q <= q_nxt;
          iter <= iter + 5'd1;
          if (iter == 5'd24) begin
            iter <= '0;
            state <= D_OUT;
            result_valid <= 1'b1;
            red_count <= sh_cnt;
            centroid_x <= cx_res;
            cy_q <= cy_res;
            steer <= steer_of(sh_cnt, min_pixels, cx_res);
          end
        end
`endif
        D_OUT: begin
          state <= D_IDLE;
          busy <= 1'b0;
        end
        default: state <= D_IDLE;
      endcase
    end
  end

`ifdef CENTROID_Y_EN
  assign centroid_y = cy_q;
`else
  assign centroid_y = '0;
`endif
endmodule

// File: tb/tb_red_centroid_tracker.sv
// Directed bench for red_centroid_tracker on an 8x4 frame, DEADBAND 1.
module tb_red_centroid_tracker;
`ifdef CENTROID_Y_EN
  localparam int LAT     = 51;
  localparam int RST_CYC = 30;
  localparam int CY_ALL  = 1;
  localparam int CY_C7   = 1;
`else
  localparam int LAT     = 26;
  localparam int RST_CYC = 15;
  localparam int CY_ALL  = 0;
  localparam int CY_C7   = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pixel;
  logic        pixel_valid, sop, eop;
  logic [3:0]  red_min, other_max;
  logic [16:0] min_pixels;
  logic [16:0] red_count;
  logic [8:0]  centroid_x;
  logic [7:0]  centroid_y;
  logic [1:0]  steer;
  logic        result_valid, overrun, busy;

  int checks = 0;
  int errors = 0;
  int pulses;
  int pulse_cyc;
  logic busy_first, busy_after;

  always #10 clk = ~clk;

  red_centroid_tracker #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .DEADBAND(1)) dut (
    .clk(clk), .reset(reset), .pixel(pixel), .pixel_valid(pixel_valid),
    .sop(sop), .eop(eop), .red_min(red_min), .other_max(other_max),
    .min_pixels(min_pixels), .red_count(red_count), .centroid_x(centroid_x),
    .centroid_y(centroid_y), .steer(steer), .result_valid(result_valid),
    .overrun(overrun), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [11:0] p, input logic s, input logic e);
    @(negedge clk);
    pixel = p; pixel_valid = 1'b1; sop = s; eop = e;
  endtask

  // mode 0: all 0xF00, mode 1: only column 7 red, mode 2: all 0x0F0
  task automatic send_frame(input int mode);
    logic [11:0] p;
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       p = 12'hF00;
        1:       p = ((i % 8) == 7) ? 12'hF00 : 12'h000;
        default: p = 12'h0F0;
      endcase
      drive(p, i == 0, i == 31);
    end
  endtask

  // Cycles counted from the eop beat (cycle 0); samples mid-cycle on negedge
  task automatic watch(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      @(negedge clk);
      pixel_valid = 1'b0; sop = 1'b0; eop = 1'b0;
      if (result_valid === 1'b1) begin
        pulses++;
        if (pulse_cyc < 0) pulse_cyc = k;
      end
      if (k == 1) busy_first = busy;
      if (k == LAT + 1) busy_after = busy;
    end
  endtask

  task automatic clr_watch();
    pulses = 0; pulse_cyc = -1; busy_first = 1'bx; busy_after = 1'bx;
  endtask

  initial begin
    reset = 1'b1; pixel = '0; pixel_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    red_min = 4'd8; other_max = 4'd4; min_pixels = 17'd1;
    repeat (3) @(negedge clk);
    chk("rst_count", red_count, 0);
    chk("rst_cx", centroid_x, 0);
    chk("rst_cy", centroid_y, 0);
    chk("rst_steer", steer, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // All red
    send_frame(0); clr_watch(); watch(1, LAT + 10);
    chk("all_pulses", pulses, 1);
    chk("all_pulse_cyc", pulse_cyc, LAT);
    chk("all_busy_c1", busy_first, 1);
    chk("all_busy_end", busy_after, 0);
    chk("all_count", red_count, 32);
    chk("all_cx", centroid_x, 3);
    chk("all_cy", centroid_y, CY_ALL);
    chk("all_steer", steer, 2);

    // Column 7 only
    send_frame(1); clr_watch(); watch(1, LAT + 5);
    chk("c7_pulse_cyc", pulse_cyc, LAT);
    chk("c7_count", red_count, 4);
    chk("c7_cx", centroid_x, 7);
    chk("c7_cy", centroid_y, CY_C7);
    chk("c7_steer", steer, 3);

    min_pixels = 17'd5;
    send_frame(1); clr_watch(); watch(1, LAT + 5);
    chk("c7min_count", red_count, 4);
    chk("c7min_steer", steer, 0);
    min_pixels = 17'd1;

    // No red pixels
    send_frame(2); clr_watch(); watch(1, LAT + 5);
    chk("zero_pulses", pulses, 1);
    chk("zero_pulse_cyc", pulse_cyc, LAT);
    chk("zero_count", red_count, 0);
    chk("zero_cx", centroid_x, 0);
    chk("zero_cy", centroid_y, 0);
    chk("zero_steer", steer, 0);
    chk("zero_overrun", overrun, 0);

    // Frame A, then frame B's eop 20 cycles later while divider busy
    send_frame(0); clr_watch();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) pulses++;
      pixel = 12'hF00; pixel_valid = 1'b1; sop = (k == 1); eop = (k == 20);
    end
    watch(21, 2 * LAT + 20);
    chk("ovr_pulses", pulses, 1);
    chk("ovr_pulse_cyc", pulse_cyc, LAT);
    chk("ovr_flag", overrun, 1);
    chk("ovr_count", red_count, 32);
    chk("ovr_cx", centroid_x, 3);

    // Frame C accepted normally afterwards
    send_frame(1); clr_watch(); watch(1, LAT + 5);
    chk("c_pulse_cyc", pulse_cyc, LAT);
    chk("c_count", red_count, 4);
    chk("c_cx", centroid_x, 7);
    chk("c_steer", steer, 3);
    chk("c_overrun_sticky", overrun, 1);

    // sop reissued at pixel 10 restarts the frame
    for (int i = 0; i < 10; i++) drive(12'hF00, i == 0, 1'b0);
    for (int i = 0; i < 32; i++) drive(12'hF00, i == 0, i == 31);
    clr_watch(); watch(1, LAT + 5);
    chk("restart_count", red_count, 32);
    chk("restart_cx", centroid_x, 3);
    chk("restart_cy", centroid_y, CY_ALL);

    // Column 7 frame so outputs are nonzero before reset abort
    send_frame(1); clr_watch(); watch(1, LAT + 5);
    chk("pre_rst_count", red_count, 4);

    // Reset mid-divide aborts the result
    send_frame(0); clr_watch(); watch(1, RST_CYC - 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    watch(RST_CYC + 2, 2 * LAT + 10);
    chk("abort_pulses", pulses, 0);
    chk("abort_count", red_count, 0);
    chk("abort_cx", centroid_x, 0);
    chk("abort_cy", centroid_y, 0);
    chk("abort_steer", steer, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_busy", busy, 0);

    // Recovery after reset
    send_frame(0); clr_watch(); watch(1, LAT + 5);
    chk("recov_pulse_cyc", pulse_cyc, LAT);
    chk("recov_count", red_count, 32);
    chk("recov_steer", steer, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
